// File: rtl/stream_logic_reducer.sv
// Streaming AND/OR/XOR reducer: folds a valid/ready packet of WIDTH-bit beats into one registered result.
// Optional beat counter and overflow flag are enabled by defining STREAM_LOGIC_REDUCER_COUNT_EN.
module stream_logic_reducer #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef STREAM_LOGIC_REDUCER_COUNT_EN
    ,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_count,
    output logic                           out_overflow
`endif
);

    if (MAX_BEATS < 1) begin : g_bad_max_beats
        $error("MAX_BEATS must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    // Encoding 11 falls through to AND.
    function automatic logic [WIDTH-1:0] reduce_op(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [1:0]       op);
        case (op)
            2'b01:   reduce_op = a | b;
            2'b10:   reduce_op = a ^ b;
            default: reduce_op = a & b;
        endcase
    endfunction

    state_t           state, state_d;
    logic [WIDTH-1:0] acc_p0, acc_d;
    logic [1:0]       op_p0, op_d;
    logic [WIDTH-1:0] out_data_p1, out_data_d;
    logic             vld_p1, vld_d;
    logic             accept;
    logic [WIDTH-1:0] next_acc;

    assign in_ready  = (state != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_p1;
    assign out_valid = vld_p1;

    always_comb begin
        state_d    = state;
        acc_d      = acc_p0;
        op_d       = op_p0;
        out_data_d = out_data_p1;
        vld_d      = vld_p1;
        next_acc   = in_data;
        if (state == ACCUM)
            next_acc = reduce_op(acc_p0, in_data, op_p0);

        if (state == HOLD && out_ready && !accept) begin
            vld_d   = 1'b0;
            state_d = IDLE;
        end
        if (accept) begin
            // Any beat outside ACCUM opens a new packet and latches its op.
            if (state != ACCUM)
                op_d = in_op;
            acc_d = next_acc;
            if (in_last) begin
                out_data_d = next_acc;
                vld_d      = 1'b1;
                state_d    = HOLD;
            end else begin
                vld_d   = 1'b0;
                state_d = ACCUM;
            end
        end
    end

    // Stage p0/p1 boundary: accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            acc_p0      <= '0;
            op_p0       <= 2'b00;
            out_data_p1 <= '0;
            vld_p1      <= 1'b0;
        end else begin
            state       <= state_d;
            acc_p0      <= acc_d;
            op_p0       <= op_d;
            out_data_p1 <= out_data_d;
            vld_p1      <= vld_d;
        end
    end

`ifdef STREAM_LOGIC_REDUCER_COUNT_EN
    localparam int CW = $clog2(MAX_BEATS + 1);

    logic [CW-1:0] cnt_p0, cnt_d, out_count_p1, out_count_d;
    logic          ovf_p0, ovf_d, out_ovf_p1, out_ovf_d;
    logic          at_max;

    assign at_max       = (cnt_p0 == CW'(MAX_BEATS));
    assign out_count    = out_count_p1;
    assign out_overflow = out_ovf_p1;

    always_comb begin
        cnt_d       = cnt_p0;
        ovf_d       = ovf_p0;
        out_count_d = out_count_p1;
        out_ovf_d   = out_ovf_p1;
        if (accept) begin
            if (state != ACCUM) begin
                cnt_d = CW'(1);
                ovf_d = 1'b0;
            end else begin
                cnt_d = at_max ? cnt_p0 : cnt_p0 + CW'(1);
                ovf_d = ovf_p0 | at_max;
            end
            if (in_last) begin
                out_count_d = cnt_d;
                out_ovf_d   = ovf_d;
            end
        end
    end

    // Stage p0/p1 boundary: beat counter and reported count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0       <= '0;
            ovf_p0       <= 1'b0;
            out_count_p1 <= '0;
            out_ovf_p1   <= 1'b0;
        end else begin
            cnt_p0       <= cnt_d;
            ovf_p0       <= ovf_d;
            out_count_p1 <= out_count_d;
            out_ovf_p1   <= out_ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_stream_logic_reducer.sv
// Directed bench for stream_logic_reducer; count checks are active when STREAM_LOGIC_REDUCER_COUNT_EN is defined.
module tb_stream_logic_reducer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic [1:0] in_op;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
`ifdef STREAM_LOGIC_REDUCER_COUNT_EN
    logic [2:0] out_count;
    logic       out_overflow;
`endif

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    stream_logic_reducer #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef STREAM_LOGIC_REDUCER_COUNT_EN
        ,
        .out_count    (out_count),
        .out_overflow (out_overflow)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic [1:0] op, input logic last, input logic v);
        in_data  = d;
        in_op    = op;
        in_last  = last;
        in_valid = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        drive(8'h00, 2'b00, 1'b0, 1'b0);
        tick;
        tick;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_in_ready", in_ready, 1'b1);
`ifdef STREAM_LOGIC_REDUCER_COUNT_EN
        check("reset_out_count", out_count, 3'd0);
        check("reset_out_overflow", out_overflow, 1'b0);
`endif
        reset = 1'b0;

        // AND: FF & F0 & 3C = 30
        drive(8'hFF, 2'b00, 1'b0, 1'b1); tick;
        check("and_b1_valid", out_valid, 1'b0);
        drive(8'hF0, 2'b00, 1'b0, 1'b1); tick;
        drive(8'h3C, 2'b00, 1'b1, 1'b1);
        check("and_before_last_valid", out_valid, 1'b0);
        tick;
        check("and_valid", out_valid, 1'b1);
        check("and_data", out_data, 8'h30);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;
        check("and_valid_one_cycle", out_valid, 1'b0);

        // XOR: 0F ^ F0 ^ FF = 00
        drive(8'h0F, 2'b10, 1'b0, 1'b1); tick;
        drive(8'hF0, 2'b10, 1'b0, 1'b1); tick;
        drive(8'hFF, 2'b10, 1'b1, 1'b1); tick;
        check("xor_valid", out_valid, 1'b1);
        check("xor_data", out_data, 8'h00);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;

        // OR: 01 | 80 = 81
        drive(8'h01, 2'b01, 1'b0, 1'b1); tick;
        drive(8'h80, 2'b01, 1'b1, 1'b1); tick;
        check("or_data", out_data, 8'h81);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;

        // Single beat ignores op
        drive(8'hA5, 2'b00, 1'b1, 1'b1); tick;
        check("single_valid", out_valid, 1'b1);
        check("single_data", out_data, 8'hA5);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;

        // Op latched on first beat: OR kept -> 01|10|02 = 13
        drive(8'h01, 2'b01, 1'b0, 1'b1); tick;
        drive(8'h10, 2'b00, 1'b0, 1'b1); tick;
        drive(8'h02, 2'b00, 1'b1, 1'b1); tick;
        check("oplatch_data", out_data, 8'h13);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;

        // Backpressure: result 5A held, presented beat 77 must wait
        out_ready = 1'b0;
        drive(8'h5A, 2'b00, 1'b1, 1'b1); tick;
        drive(8'h77, 2'b00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", in_ready, 1'b0);
            tick;
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, 8'h5A);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        tick;
        check("bp_taken_valid", out_valid, 1'b0);
        drive(8'h0F, 2'b10, 1'b1, 1'b1); tick;
        check("bp_newpkt_valid", out_valid, 1'b1);
        check("bp_newpkt_data", out_data, 8'h07);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;
        check("bp_idle_valid", out_valid, 1'b0);

        // Back-to-back single-beat packets
        drive(8'h11, 2'b00, 1'b1, 1'b1);
        check("b2b_ready0", in_ready, 1'b1);
        tick;
        check("b2b_data0", out_data, 8'h11);
        check("b2b_valid0", out_valid, 1'b1);
        drive(8'h22, 2'b01, 1'b1, 1'b1);
        check("b2b_ready1", in_ready, 1'b1);
        tick;
        check("b2b_data1", out_data, 8'h22);
        check("b2b_valid1", out_valid, 1'b1);
        drive(8'h33, 2'b10, 1'b1, 1'b1);
        check("b2b_ready2", in_ready, 1'b1);
        tick;
        check("b2b_data2", out_data, 8'h33);
        check("b2b_valid2", out_valid, 1'b1);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;
        check("b2b_idle_valid", out_valid, 1'b0);

        // Reset mid-packet discards 0F,0E
        drive(8'h0F, 2'b00, 1'b0, 1'b1); tick;
        drive(8'h0E, 2'b00, 1'b0, 1'b1); tick;
        drive(8'h00, 2'b00, 1'b0, 1'b0);
        reset = 1'b1;
        tick;
        check("rst_mid_valid_during", out_valid, 1'b0);
        reset = 1'b0;
        tick;
        check("rst_mid_valid_after", out_valid, 1'b0);
        drive(8'h81, 2'b00, 1'b1, 1'b1); tick;
        check("rst_mid_valid", out_valid, 1'b1);
        check("rst_mid_data", out_data, 8'h81);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;

`ifdef STREAM_LOGIC_REDUCER_COUNT_EN
        // Counter with MAX_BEATS=4
        for (int i = 0; i < 3; i++) begin
            drive(8'hFF, 2'b00, (i == 2), 1'b1); tick;
        end
        check("cnt3_count", out_count, 3'd3);
        check("cnt3_ovf", out_overflow, 1'b0);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;
        for (int i = 0; i < 6; i++) begin
            drive(8'h01, 2'b01, (i == 5), 1'b1); tick;
        end
        check("cnt6_count", out_count, 3'd4);
        check("cnt6_ovf", out_overflow, 1'b1);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;
        drive(8'h42, 2'b00, 1'b1, 1'b1); tick;
        check("cnt1_count", out_count, 3'd1);
        check("cnt1_ovf", out_overflow, 1'b0);
        check("cnt1_data", out_data, 8'h42);
        drive(8'h00, 2'b00, 1'b0, 1'b0); tick;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stream_logic_reducer.md
Name: stream_logic_reducer

Overview:
- Streaming bitwise reduction engine; the parametrised, sequential successor to the team's single-gate logic checks.
- Folds a packet of WIDTH-bit beats into one WIDTH-bit result using AND, OR or XOR. The operation is selected per packet.
- Sits between a valid/ready producer (ADC sample or USB byte path) and a valid/ready consumer. Typical uses are mask/parity/coverage summaries of captured data.
- One-entry registered output with full backpressure support.

Parameters:
- WIDTH, 8, bit width of input beats and of the result.
- MAX_BEATS, 256, saturation limit of the optional beat counter; must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input beat.
- in_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 treated as AND; sampled on the first beat of a packet only.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat valid.
- in_ready  output  1  engine can accept a beat.
- out_data  output  WIDTH  reduced result.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: synchronous on clk, active-high.
  - Reset values: out_valid=0, out_data=0, accumulator=0, state=IDLE, latched op=AND.
  - Reset mid-packet discards the partial accumulation; the next accepted beat is a first beat.
- Transfer rule: an input beat is accepted when in_valid && in_ready; a result is taken when out_valid && out_ready.
- in_ready is combinational: in_ready = (state != HOLD) || out_ready. This gives zero-bubble back-to-back packets.
- States:
  - IDLE: no beats accumulated.
    - Accepted beat: acc<=in_data, op_q<=in_op.
    - If in_last: out_data<=in_data, out_valid<=1, go to HOLD; else go to ACCUM.
  - ACCUM: each accepted beat sets acc<=acc op_q in_data.
    - in_op is ignored in this state.
    - If in_last: out_data<=(acc op_q in_data), out_valid<=1, go to HOLD.
  - HOLD: out_valid=1; out_data and out_valid are held stable until out_ready.
    - out_ready without an accepted beat: out_valid<=0, go to IDLE.
    - out_ready with an accepted beat in the same cycle: the beat is the first beat of a new packet, handled exactly as in IDLE.
    - If that beat also has in_last, out_valid stays 1 and out_data takes the new value (single-beat packet).
- Latency: out_valid rises on the cycle after the accepted last beat.
- Single-beat packet: out_data = in_data regardless of op.
- in_valid with in_ready low: no state change; the producer must hold its beat.
- Width rules: all operations are pure bitwise over WIDTH bits; no carries or truncation.
- out_data, out_valid and the optional count outputs come from registers; no combinational path from inputs to them.

Optional Feature:
- Macro name: STREAM_LOGIC_REDUCER_COUNT_EN.
- When defined, two extra output ports are added:
  - out_count, width $clog2(MAX_BEATS+1): number of beats in the reported packet.
  - out_overflow, 1 bit: set when the packet exceeded MAX_BEATS.
- Counter behaviour:
  - The counter loads 1 on the first beat and increments per accepted beat, saturating at MAX_BEATS.
  - A sticky overflow flag is set if a beat is accepted while the count equals MAX_BEATS; it clears on each first beat.
  - out_count and out_overflow register with out_data, have the same stability rule in HOLD, and reset to 0.
- When undefined: the ports and counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Multi-beat AND/OR/XOR: check result value and latency.
  - op=00, beats 0xFF,0xF0,0x3C(last) -> out_data=0x30, out_valid high exactly one cycle after the last beat.
  - op=10, beats 0x0F,0xF0,0xFF(last) -> 0x00.
  - op=01, beats 0x01,0x80(last) -> 0x81.
- Single-beat packet and op latching:
  - op=00, 0xA5(last) -> 0xA5.
  - op=01 on the first beat, then in_op=00 on later beats 0x10,0x02(last) after 0x01 -> 0x13 (OR kept).
- Backpressure: out_ready=0 for 5 cycles after a result.
  - out_data stable, out_valid=1, in_ready=0, and a presented beat is not accepted.
  - Then out_ready=1 with a valid beat in the same cycle -> both transfers occur, and the next result reflects only the new packet.
- Back-to-back single-beat packets with out_ready=1: inputs 0x11,0x22,0x33 on consecutive cycles, each with last.
  - Outputs 0x11,0x22,0x33 on consecutive cycles; in_ready never low.
- Reset mid-packet: accept 0x0F, 0x0E without last, pulse reset 1 cycle, then send 0x81(last) with op=00.
  - out_valid=0 during and after reset until the new result; result = 0x81.
- COUNT_EN: with MAX_BEATS=4:
  - 3-beat packet -> out_count=3, out_overflow=0.
  - 6-beat packet -> out_count=4, out_overflow=1.
  - Following 1-beat packet -> out_count=1, out_overflow=0.
